// File: rtl/load_store_port_arbiter.sv
// Arbitrates the single data-memory port between the load-queue head and the store-queue head.
// Optional store-starvation guard is enabled with macro LS_ARB_STARVE_GUARD_EN.
module load_store_port_arbiter #(
    parameter int STARVE_LIMIT = 8,
    parameter int CNT_W        = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic load_valid,
    input  logic load_conflict,
    input  logic load_is_amo_rmw,
    output logic load_pop,
    input  logic sq_valid,
    input  logic sq_is_amo_rmw,
    input  logic sq_empty,
    output logic sq_pop,
    input  logic port_ready,
    output logic port_valid,
    output logic port_sel_store,
    input  logic fence_req,
    output logic fence_done,
    output logic amo_locked
);

    typedef enum logic [1:0] {NORMAL, AMO_WAIT, DRAIN} state_t;

    state_t state_q, state_d;
    logic   fence_done_q, fence_done_d;
    logic   ld_ok, st_ok, starved;
    logic   ld_pick, st_pick;

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255 || (STARVE_LIMIT >> CNT_W) != 0) begin : g_bad_cfg
        $error("load_store_port_arbiter: STARVE_LIMIT must be 1..255 and below 2**CNT_W");
    end

    assign ld_ok = load_valid & ~load_conflict;
    assign st_ok = sq_valid;

`ifdef LS_ARB_STARVE_GUARD_EN
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

    assign starved = (starve_cnt_q >= CNT_W'(STARVE_LIMIT));

    // Counts consecutive load grants that overtook a released store; saturates at the limit.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (sq_pop || !sq_valid) begin
            starve_cnt_d = '0;
        end else if (load_pop && !starved) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    assign starved = 1'b0;
`endif

    always_comb begin
        ld_pick      = 1'b0;
        st_pick      = 1'b0;
        state_d      = state_q;
        fence_done_d = 1'b0;
        unique case (state_q)
            NORMAL: begin
                // A pending fence stops new loads so the store queue can drain.
                ld_pick = ld_ok & ~fence_req;
                st_pick = st_ok & (~ld_pick | starved);
                ld_pick = ld_pick & ~st_pick;
            end
            AMO_WAIT: st_pick = sq_valid & sq_is_amo_rmw;
            DRAIN:    st_pick = st_ok;
            default:  ;
        endcase

        load_pop = ld_pick & port_ready;
        sq_pop   = st_pick & port_ready;

        unique case (state_q)
            NORMAL: begin
                if (load_pop && load_is_amo_rmw) begin
                    state_d = AMO_WAIT;
                end else if (fence_req && port_ready && !sq_pop) begin
                    state_d = DRAIN;
                end
            end
            AMO_WAIT: begin
                if (sq_pop) begin
                    state_d = NORMAL;
                end
            end
            DRAIN: begin
                // Completion is independent of port_ready: an empty queue needs no port access.
                if (sq_empty && !sq_pop) begin
                    state_d      = NORMAL;
                    fence_done_d = 1'b1;
                end
            end
            default: state_d = NORMAL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= NORMAL;
            fence_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            fence_done_q <= fence_done_d;
        end
    end

    assign port_valid     = load_pop | sq_pop;
    assign port_sel_store = sq_pop;
    assign fence_done     = fence_done_q;
    assign amo_locked     = (state_q == AMO_WAIT);

endmodule

// File: tb/tb_load_store_port_arbiter.sv
// Bench for load_store_port_arbiter: directed scenarios plus randomized traffic against a reference model.
module tb_load_store_port_arbiter;

    localparam int LIMIT = 8;
`ifdef LS_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic load_valid, load_conflict, load_is_amo_rmw, load_pop;
    logic sq_valid, sq_is_amo_rmw, sq_empty, sq_pop;
    logic port_ready, port_valid, port_sel_store;
    logic fence_req, fence_done, amo_locked;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    load_store_port_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .load_valid     (load_valid),
        .load_conflict  (load_conflict),
        .load_is_amo_rmw(load_is_amo_rmw),
        .load_pop       (load_pop),
        .sq_valid       (sq_valid),
        .sq_is_amo_rmw  (sq_is_amo_rmw),
        .sq_empty       (sq_empty),
        .sq_pop         (sq_pop),
        .port_ready     (port_ready),
        .port_valid     (port_valid),
        .port_sel_store (port_sel_store),
        .fence_req      (fence_req),
        .fence_done     (fence_done),
        .amo_locked     (amo_locked)
    );

    task automatic idle_inputs();
        load_valid = 0; load_conflict = 0; load_is_amo_rmw = 0;
        sq_valid = 0; sq_is_amo_rmw = 0; sq_empty = 1;
        port_ready = 0; fence_req = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        @(posedge clk); #1;
        @(negedge clk);
        total++;
        if ({load_pop, sq_pop, port_valid, port_sel_store, fence_done, amo_locked} !== 6'b0) begin
            bad++;
            $display("FAIL reset_outputs got=%b want=000000",
                     {load_pop, sq_pop, port_valid, port_sel_store, fence_done, amo_locked});
        end
        @(posedge clk); #1;
        rst = 0;
    endtask

    task automatic test_contention();
        int n_ld, n_st;
        bit exp_st;
        do_reset();
        load_valid = 1; sq_valid = 1; sq_empty = 0; port_ready = 1;
        n_ld = 0; n_st = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            exp_st = GUARD && ((i % (LIMIT + 1)) == LIMIT);
            n_ld += int'(load_pop);
            n_st += int'(sq_pop);
            total++;
            if ({load_pop, sq_pop, port_valid, port_sel_store} !== {~exp_st, exp_st, 1'b1, exp_st}) begin
                bad++;
                $display("FAIL contention cyc=%0d ld/st/pv/sel got=%b%b%b%b want=%b%b1%b",
                         i, load_pop, sq_pop, port_valid, port_sel_store, ~exp_st, exp_st, exp_st);
            end
            next_cycle();
        end
        total++;
        if (n_ld != (GUARD ? 18 : 20) || n_st != (GUARD ? 2 : 0)) begin
            bad++;
            $display("FAIL contention_totals loads=%0d stores=%0d want loads=%0d stores=%0d",
                     n_ld, n_st, GUARD ? 18 : 20, GUARD ? 2 : 0);
        end
    endtask

    task automatic test_conflict();
        do_reset();
        load_valid = 1; load_conflict = 1; sq_valid = 1; sq_empty = 0; port_ready = 1;
        @(negedge clk);
        total++;
        if ({load_pop, sq_pop, port_sel_store} !== 3'b011) begin
            bad++;
            $display("FAIL conflict ld/st/sel got=%b%b%b want=011", load_pop, sq_pop, port_sel_store);
        end
        load_conflict = 0;
        #1;
        total++;
        if ({load_pop, sq_pop, port_sel_store} !== 3'b100) begin
            bad++;
            $display("FAIL conflict_release ld/st/sel got=%b%b%b want=100", load_pop, sq_pop, port_sel_store);
        end
        next_cycle();
    endtask

    task automatic test_amo();
        do_reset();
        load_valid = 1; load_is_amo_rmw = 1; port_ready = 1;
        @(negedge clk);
        total++;
        if (load_pop !== 1'b1) begin
            bad++;
            $display("FAIL amo_load_grant got=%b want=1", load_pop);
        end
        next_cycle();
        load_is_amo_rmw = 0; sq_valid = 1; sq_empty = 0; sq_is_amo_rmw = 0;
        for (int i = 1; i <= 2; i++) begin
            @(negedge clk);
            total++;
            if ({load_pop, sq_pop, amo_locked} !== 3'b001) begin
                bad++;
                $display("FAIL amo_blocked N+%0d ld/st/lock got=%b%b%b want=001", i, load_pop, sq_pop, amo_locked);
            end
            next_cycle();
        end
        sq_is_amo_rmw = 1;
        @(negedge clk);
        total++;
        if ({load_pop, sq_pop, amo_locked} !== 3'b011) begin
            bad++;
            $display("FAIL amo_store N+3 ld/st/lock got=%b%b%b want=011", load_pop, sq_pop, amo_locked);
        end
        next_cycle();
        sq_valid = 0; sq_is_amo_rmw = 0; sq_empty = 1;
        @(negedge clk);
        total++;
        if ({load_pop, amo_locked} !== 2'b10) begin
            bad++;
            $display("FAIL amo_release N+4 ld/lock got=%b%b want=10", load_pop, amo_locked);
        end
        next_cycle();
    endtask

    task automatic test_fence();
        do_reset();
        load_valid = 1; sq_valid = 1; sq_empty = 0; fence_req = 1; port_ready = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if ({load_pop, sq_pop, fence_done} !== 3'b010) begin
                bad++;
                $display("FAIL fence_store%0d ld/st/done got=%b%b%b want=010", i, load_pop, sq_pop, fence_done);
            end
            next_cycle();
        end
        sq_valid = 0; sq_empty = 1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++;
            if ({load_pop, sq_pop, fence_done} !== 3'b000) begin
                bad++;
                $display("FAIL fence_wait%0d ld/st/done got=%b%b%b want=000", i, load_pop, sq_pop, fence_done);
            end
            next_cycle();
        end
        fence_req = 0;
        @(negedge clk);
        total++;
        if ({load_pop, fence_done} !== 2'b11) begin
            bad++;
            $display("FAIL fence_done_pulse ld/done got=%b%b want=11", load_pop, fence_done);
        end
        next_cycle();
        @(negedge clk);
        total++;
        if ({load_pop, fence_done} !== 2'b10) begin
            bad++;
            $display("FAIL fence_done_single ld/done got=%b%b want=10", load_pop, fence_done);
        end
        next_cycle();
    endtask

    task automatic test_reset_drain();
        do_reset();
        load_valid = 1; sq_valid = 0; sq_empty = 0; fence_req = 1; port_ready = 1;
        next_cycle();
        @(negedge clk);
        total++;
        if ({load_pop, sq_pop, amo_locked} !== 3'b000) begin
            bad++;
            $display("FAIL drain_blocks ld/st/lock got=%b%b%b want=000", load_pop, sq_pop, amo_locked);
        end
        next_cycle();
        rst = 1; fence_req = 0; sq_empty = 1;
        next_cycle();
        rst = 0; sq_valid = 1; sq_empty = 0;
        @(negedge clk);
        total++;
        if ({load_pop, sq_pop, fence_done, amo_locked} !== 4'b1000) begin
            bad++;
            $display("FAIL reset_in_drain ld/st/done/lock got=%b%b%b%b want=1000",
                     load_pop, sq_pop, fence_done, amo_locked);
        end
        next_cycle();
    endtask

    // Reference: mode 0 normal, 1 waiting for AMO store, 2 draining for fence.
    task automatic test_random();
        int  mode, streak;
        bit  fdone, e_ld, e_st, ld_ok, want_ld;
        do_reset();
        mode = 0; streak = 0; fdone = 0;
        for (int i = 0; i < 3000; i++) begin
            load_valid      = ($urandom % 4) != 0;
            load_conflict   = ($urandom % 4) == 0;
            load_is_amo_rmw = ($urandom % 7) == 0;
            sq_valid        = ($urandom % 2) == 0;
            sq_is_amo_rmw   = ($urandom % 3) == 0;
            sq_empty        = sq_valid ? 1'b0 : 1'($urandom % 2);
            port_ready      = ($urandom % 5) != 0;
            if (fdone)           fence_req = 0;
            else if (!fence_req) fence_req = ($urandom % 25) == 0;

            ld_ok = load_valid && !load_conflict;
            e_ld = 0; e_st = 0;
            if (mode == 0) begin
                want_ld = ld_ok && !fence_req;
                e_st = sq_valid && (!want_ld || (GUARD && streak >= LIMIT));
                e_ld = want_ld && !e_st;
            end else if (mode == 1) begin
                e_st = sq_valid && sq_is_amo_rmw;
            end else begin
                e_st = sq_valid;
            end
            e_ld = e_ld && port_ready;
            e_st = e_st && port_ready;

            @(negedge clk);
            total++;
            if ({load_pop, sq_pop, port_valid, port_sel_store, fence_done, amo_locked} !==
                {e_ld, e_st, e_ld | e_st, e_st, fdone, mode == 1}) begin
                bad++;
                $display("FAIL random cyc=%0d ld/st/pv/sel/done/lock got=%b want=%b", i,
                         {load_pop, sq_pop, port_valid, port_sel_store, fence_done, amo_locked},
                         {e_ld, e_st, e_ld | e_st, e_st, fdone, mode == 1});
            end

            fdone = 0;
            if (mode == 0) begin
                if (e_ld && load_is_amo_rmw)                mode = 1;
                else if (fence_req && port_ready && !e_st)  mode = 2;
            end else if (mode == 1) begin
                if (e_st) mode = 0;
            end else if (sq_empty && !e_st) begin
                mode = 0; fdone = 1;
            end
            if (e_st || !sq_valid)           streak = 0;
            else if (e_ld && streak < LIMIT) streak++;
            next_cycle();
        end
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        test_reset();
        test_contention();
        test_conflict();
        test_amo();
        test_fence();
        test_reset_drain();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/load_store_port_arbiter.md
# load_store_port_arbiter

Sequences the single data-memory port between the load-queue head and the store-queue head.
- Grants at most one request per cycle.
- Holds loads off while a store conflict is flagged.
- Keeps an AMO read-modify-write's load and its paired store back-to-back.
- Drains the store queue for fences.
- Bounds store starvation under sustained load traffic.

Sits in the load/store unit between the load queue, the store queue and the memory sub-unit mux.

## Interface
Parameters:
- STARVE_LIMIT, default 8: consecutive load grants allowed while a released store waits. Legal range 1..255.
- CNT_W, default 8: width of the starvation counter. Must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
- clk, in, 1: clock.
- rst, in, 1: synchronous, active-high reset.
- load_valid, in, 1: load-queue head is valid.
- load_conflict, in, 1: store-queue collision check for the head load; the load may not issue.
- load_is_amo_rmw, in, 1: head load is the read half of an AMO read-modify-write.
- load_pop, out, 1: load granted this cycle.
- sq_valid, in, 1: store-queue head is valid and released.
- sq_is_amo_rmw, in, 1: store-queue head is the write half of an AMO read-modify-write.
- sq_empty, in, 1: store queue holds no entries.
- sq_pop, out, 1: store granted this cycle.
- port_ready, in, 1: memory sub-unit accepts a request this cycle.
- port_valid, out, 1: request presented to the port; equals load_pop | sq_pop.
- port_sel_store, out, 1: port mux select; 1 = store, 0 = load.
- fence_req, in, 1: level signal, held until fence_done.
- fence_done, out, 1: registered, one-cycle pulse.
- amo_locked, out, 1: high in state AMO_WAIT.

## Operation
- FSM states: NORMAL, AMO_WAIT, DRAIN.
- Candidate definitions:
  - ld_ok = load_valid & ~load_conflict.
  - st_ok = sq_valid.
- Grants are combinational; both are qualified by port_ready. load_pop and sq_pop are never high together.
- NORMAL priority:
  - Store wins if st_ok and (~ld_ok, or starve_cnt >= STARVE_LIMIT).
  - Otherwise load wins if ld_ok.
- NORMAL transitions:
  - A load grant with load_is_amo_rmw goes to AMO_WAIT.
  - fence_req with no grant this cycle goes to DRAIN.
  - fence_req has priority over a new load: while fence_req is high in NORMAL, loads are not granted; stores are.
- AMO_WAIT:
  - Loads are blocked.
  - A store is granted only if sq_valid & sq_is_amo_rmw; a non-AMO head store is blocked.
  - On that grant, return to NORMAL.
  - fence_req is ignored until back in NORMAL.
- DRAIN:
  - Loads are blocked; stores are granted when st_ok.
  - When sq_empty is sampled high with no sq_pop that cycle, pulse fence_done the next cycle and return to NORMAL.
  - If sq_empty is already high on entry, fence_done pulses one cycle after entry.
- starve_cnt, CNT_W bits:
  - Cleared on a store grant, or when sq_valid = 0.
  - Incremented on a load grant while sq_valid = 1.
  - Saturates at STARVE_LIMIT; never wraps.
- port_sel_store equals sq_pop, and is 0 when no grant.

## Timing
- Grant latency: 0 cycles, same cycle as port_ready.
- State, starve_cnt and fence_done update on the clock edge following the grant or condition.
- Minimum fence latency, from fence_req rise in NORMAL with sq_empty high: DRAIN on edge 1, fence_done high on edge 2.
- AMO pair: the load grant on cycle N. The earliest paired store grant is cycle N+1.
- Reset values, applied on the first clk edge with rst high:
  - State = NORMAL, starve_cnt = 0, fence_done = 0.
  - Combinational outputs follow from state; with inputs idle, all outputs are 0.
- Reset mid-AMO or mid-DRAIN abandons the sequence; no fence_done is issued.
- port_ready low blocks all grants. State holds, except that DRAIN completion on sq_empty still occurs.

## Configuration
- Macro LS_ARB_STARVE_GUARD_EN.
- Defined: starve_cnt and the forced store priority exist as described above.
- Undefined: starve_cnt is removed, and loads strictly win over stores in NORMAL whenever ld_ok. STARVE_LIMIT and CNT_W are accepted but unused.

## Test plan
- Contention, guard on, STARVE_LIMIT=8: ld_ok and st_ok held high with port_ready=1 -> loads are granted on cycles 0..7, the store on cycle 8, and starve_cnt is 0 on cycle 9.
- Conflict: load_valid=1, load_conflict=1, sq_valid=1 -> sq_pop=1, port_sel_store=1, load_pop=0. Drop load_conflict -> load_pop=1 the same cycle.
- AMO pair: AMO load granted on cycle N, then sq_valid=1 with sq_is_amo_rmw=0 -> no grant and amo_locked=1. Assert sq_is_amo_rmw on cycle N+3 -> sq_pop=1 on N+3, NORMAL on N+4.
- Fence with 3 queued stores: fence_req raised while load_valid=1 -> no load_pop. Three sq_pop are granted, then sq_empty -> one fence_done pulse, then loads resume.
- Guard compiled out: ld_ok and st_ok held for 20 cycles -> 20 load_pop and 0 sq_pop.
- Reset asserted in DRAIN with 2 stores pending -> next cycle state is NORMAL, fence_done=0 and starve_cnt=0.
